prog_feeder: RTL

- Instruction-side initiator for the simple processor datapath and its control unit.
- Holds a small program RAM, loaded through a write port.
- Presents instruction words on DIN with a one-cycle RUN strobe, then supplies the immediate word for mvi.
- Waits for DONE before issuing the next word; stops on a HALT word, an illegal opcode, or a DONE timeout.

---
 rtl/prog_feeder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/prog_feeder.sv
// prog_feeder: small program RAM plus a sequencer that issues instruction words (and mvi immediates)
// to the processor bus, waiting for DONE. Optional single-step PAUSE state: PROG_FEEDER_STEP_EN.
module prog_feeder #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 9,
    parameter int TIMEOUT = 7
) (
    input  logic              CLOCK,
    input  logic              RESETN,
    input  logic              START,
`ifdef PROG_FEEDER_STEP_EN
    input  logic              STEP,
`endif
    input  logic              LOAD_WE,
    input  logic [ADDR_W-1:0] LOAD_ADDR,
    input  logic [DATA_W-1:0] LOAD_DATA,
    input  logic              DONE,
    output logic [DATA_W-1:0] DIN,
    output logic              RUN,
    output logic [ADDR_W-1:0] PC,
    output logic              BUSY,
    output logic              HALTED,
    output logic              ERROR
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6,
        S_PAUSE  = 3'd7
    } state_t;

    localparam logic [2:0]        OP_HALT   = 3'd0;
    localparam logic [2:0]        OP_MVI    = 3'd2;
    localparam logic [2:0]        OP_SUB    = 3'd4;
    localparam logic [ADDR_W-1:0] PC_ONE    = ADDR_W'(1);
    localparam logic [7:0]        TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [7:0]        CNT_ONE   = 8'd1;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                run_q, run_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [7:0]          cnt_q, cnt_d;

    logic [DATA_W-1:0]   mem [2**ADDR_W];
    logic [DATA_W-1:0]   mem_rd;
    logic [2:0]          opcode;
    logic                load_ok;

    assign mem_rd  = mem[pc_q];
    assign opcode  = word_q[DATA_W-1 -: 3];
    assign load_ok = (state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERR);

    // Program RAM: no reset, writes only while the sequencer is parked.
    always_ff @(posedge CLOCK) begin
        if (LOAD_WE && load_ok) begin
            mem[LOAD_ADDR] <= LOAD_DATA;
        end
    end

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            din_q   <= '0;
            word_q  <= '0;
            run_q   <= 1'b0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            word_q  <= word_d;
            run_q   <= run_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        word_d  = word_q;
        run_d   = 1'b0;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_HALT, S_ERR: begin
                // A simultaneous load takes priority over START.
                if (START && !LOAD_WE) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                word_d  = mem_rd;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else if (opcode > OP_SUB) begin
                    state_d = S_ERR;
                end else begin
                    din_d   = word_q;
                    run_d   = 1'b1;
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (opcode == OP_MVI) begin
                    din_d = mem_rd;
                    pc_d  = pc_q + PC_ONE;
                end
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (DONE) begin
`ifdef PROG_FEEDER_STEP_EN
                    state_d = S_PAUSE;
`else
                    state_d = S_FETCH;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_d == TIMEOUT_C) begin
                        state_d = S_ERR;
                    end
                end
            end
`ifdef PROG_FEEDER_STEP_EN
            S_PAUSE: begin
                if (STEP) begin
                    state_d = S_FETCH;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign DIN    = din_q;
    assign RUN    = run_q;
    assign PC     = pc_q;
    assign BUSY   = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_ISSUE) ||
                    (state_q == S_WAIT)  || (state_q == S_PAUSE);
    assign HALTED = (state_q == S_HALT);
    assign ERROR  = (state_q == S_ERR);

endmodule
